cache_mem_arbiter: RTL

//  Shares the single multi-cycle main memory between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores.

---
 rtl/cache_mem_arbiter_pkg.sv | 24 ++
 rtl/cache_mem_arbiter_if.sv | 46 ++++
 rtl/cache_mem_arbiter_burst_counter.sv | 43 ++++
 rtl/cache_mem_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// cache_arb_pkg: shared types and constants for the cache/memory arbiter.
//   arb_state_e     - arbiter FSM states
//   BLOCK_WORDS_DEF - default words per cache block (power of 2)
//   MEM_LATENCY     - memory read latency the burst timing assumes
//   BLK_OFF_W       - byte-offset bits covering one block
//   CNT_W           - burst counter width (counts 0..BLOCK_WORDS inclusive)
//   ARB_FILL_D/I    - encoding of the last-served-fill flop
package cache_arb_pkg;

  function automatic int cnt_w(input int bw);
    return $clog2(bw) + 1;
  endfunction

  localparam int BLOCK_WORDS_DEF = 8;
  localparam int MEM_LATENCY     = 4;
  localparam int BLK_OFF_W       = cnt_w(BLOCK_WORDS_DEF);
  localparam int CNT_W           = cnt_w(BLOCK_WORDS_DEF);

  localparam logic ARB_FILL_D = 1'b0;
  localparam logic ARB_FILL_I = 1'b1;

  typedef enum logic [1:0] {IDLE, WRITE, DFILL, IFILL} arb_state_e;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: cache-side requests and memory-side bus of the arbiter.
//   slave  - arbiter view (takes requests, drives grants and memory strobes)
//   master - environment view (caches and memory model)
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_fill_req;
  logic [ADDR_W-1:0] i_fill_addr;
  logic              i_fill_grant;
  logic              i_data_valid;
  logic              i_fill_done;

  logic              d_fill_req;
  logic [ADDR_W-1:0] d_fill_addr;
  logic              d_fill_grant;
  logic              d_data_valid;
  logic              d_fill_done;

  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              d_wr_ack;

  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_data_valid;

  modport slave (
    input  i_fill_req, i_fill_addr, d_fill_req, d_fill_addr,
           d_wr_req, d_wr_addr, d_wr_data, mem_data_valid,
    output i_fill_grant, i_data_valid, i_fill_done,
           d_fill_grant, d_data_valid, d_fill_done, d_wr_ack,
           mem_enable, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_fill_req, i_fill_addr, d_fill_req, d_fill_addr,
           d_wr_req, d_wr_addr, d_wr_data, mem_data_valid,
    input  i_fill_grant, i_data_valid, i_fill_done,
           d_fill_grant, d_data_valid, d_fill_done, d_wr_ack,
           mem_enable, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter_burst_counter.sv
// arb_burst_counter: issue and return word counters for one block burst.
//   clr      - synchronous clear of both counters (held while idle)
//   iss_inc  - one read issued this cycle
//   ret_inc  - one read word returned this cycle
//   iss_idx  - word index of the next read to issue
//   iss_done - all BLOCK_WORDS reads issued
//   ret_last - the next returned word is the last of the block
// Counters saturate at BLOCK_WORDS; they never wrap.
module arb_burst_counter #(
  parameter int BLOCK_WORDS = 8,
  parameter int CW          = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          iss_inc,
  input  logic          ret_inc,
  output logic [CW-2:0] iss_idx,
  output logic          iss_done,
  output logic          ret_last
);
  localparam logic [CW-1:0] FULL = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

  logic [CW-1:0] iss_cnt, ret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_cnt <= '0;
      ret_cnt <= '0;
    end else if (clr) begin
      iss_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (iss_inc && iss_cnt != FULL) iss_cnt <= iss_cnt + CW'(1);
      if (ret_inc && ret_cnt != FULL) ret_cnt <= ret_cnt + CW'(1);
    end
  end

  assign iss_idx  = iss_cnt[CW-2:0];
  assign iss_done = (iss_cnt == FULL);
  assign ret_last = (ret_cnt == LAST);
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one multi-cycle memory between I-cache fills,
// D-cache fills and D-cache write-through stores.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - cache_mem_arbiter_if.slave: fill/store requests, grants,
//                per-cache data_valid/done, memory strobe/address/data
// A fill owns memory for a whole block: BLOCK_WORDS back-to-back reads,
// then waits for every word to return before releasing. Arbitration happens
// only in the single IDLE cycle between accesses; stores have top priority.
// Optional feature macro ARB_ROUND_ROBIN_EN: alternate D/I fills when both
// are requested together (default build: D fill always beats I fill).
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input logic                clk,
  input logic                rst_n,
  cache_mem_arbiter_if.slave bus
);
  localparam int CW    = cnt_w(BLOCK_WORDS);
  localparam int OFF_W = CW;  // word-index bits plus the byte bit

  arb_state_e state_q, state_d;
  logic [ADDR_W-OFF_W-1:0] base_q;
  logic                    pick_d, fill_start;
  logic                    cnt_clr, iss_inc, ret_inc, iss_done, ret_last;
  logic [CW-2:0]           iss_idx;

  // Block offset bits of the miss addresses are replaced by the burst index.
  logic unused_lo;
  assign unused_lo = ^{bus.i_fill_addr[OFF_W-1:0], bus.d_fill_addr[OFF_W-1:0]};

  arb_burst_counter #(.BLOCK_WORDS(BLOCK_WORDS), .CW(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .iss_inc  (iss_inc),
    .ret_inc  (ret_inc),
    .iss_idx  (iss_idx),
    .iss_done (iss_done),
    .ret_last (ret_last)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_fill_q;
  // On a tie, serve whichever fill type did not go last.
  assign pick_d = bus.d_fill_req && (!bus.i_fill_req || last_fill_q == ARB_FILL_I);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          last_fill_q <= ARB_FILL_I;
    else if (fill_start) last_fill_q <= pick_d ? ARB_FILL_D : ARB_FILL_I;
  end
`else
  assign pick_d = bus.d_fill_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (fill_start)
        base_q <= pick_d ? bus.d_fill_addr[ADDR_W-1:OFF_W] : bus.i_fill_addr[ADDR_W-1:OFF_W];
    end
  end

  always_comb begin
    state_d          = state_q;
    fill_start       = 1'b0;
    cnt_clr          = 1'b0;
    iss_inc          = 1'b0;
    ret_inc          = 1'b0;
    bus.i_fill_grant = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_fill_done  = 1'b0;
    bus.d_fill_grant = 1'b0;
    bus.d_data_valid = 1'b0;
    bus.d_fill_done  = 1'b0;
    bus.d_wr_ack     = 1'b0;
    bus.mem_enable   = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = {DATA_W{1'b0}};
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (bus.d_wr_req) begin
          state_d = WRITE;
        end else if (bus.d_fill_req || bus.i_fill_req) begin
          fill_start = 1'b1;
          state_d    = pick_d ? DFILL : IFILL;
        end
      end
      WRITE: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = bus.d_wr_addr;
        bus.mem_wdata  = bus.d_wr_data;
        bus.d_wr_ack   = 1'b1;
        state_d        = IDLE;
      end
      DFILL, IFILL: begin
        if (state_q == DFILL) bus.d_fill_grant = 1'b1;
        else                  bus.i_fill_grant = 1'b1;
        // Issue phase overlaps the start of the return phase.
        if (!iss_done) begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = {base_q, iss_idx, 1'b0};
          iss_inc        = 1'b1;
        end
        ret_inc = bus.mem_data_valid;
        if (state_q == DFILL) bus.d_data_valid = bus.mem_data_valid;
        else                  bus.i_data_valid = bus.mem_data_valid;
        if (bus.mem_data_valid && ret_last) begin
          if (state_q == DFILL) bus.d_fill_done = 1'b1;
          else                  bus.i_fill_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
